// File: rtl/shiftreg_loader_if.sv
// Bundle between the system bus, shiftreg_loader and the shift-register pins.
// Latency: none (wires only).
// Backpressure: load_valid/load_ready handshake; clear_req is a level request.
//
// slave  : the loader side (takes word/requests, drives the register pins)
// master : the system side (drives word/requests, observes status and pins)
//   data_in    word to shift out          load_valid/load_ready  handshake
//   clear_req  zero the register outputs  oe_en                  output enable request
//   busy/done  status                     din/shcp/stcp/oe/sr_reset  register pins
interface shiftreg_loader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             clear_req;
  logic             oe_en;
  logic             busy;
  logic             done;
  logic             din;
  logic             shcp;
  logic             stcp;
  logic             oe;
  logic             sr_reset;

  modport slave (
    input  data_in, load_valid, clear_req, oe_en,
    output load_ready, busy, done, din, shcp, stcp, oe, sr_reset
  );

  modport master (
    output data_in, load_valid, clear_req, oe_en,
    input  load_ready, busy, done, din, shcp, stcp, oe, sr_reset
  );
endinterface

// File: rtl/shiftreg_loader.sv
// Sequencer for a serial-in/parallel-out shift register: serialises a word onto din with shcp, then pulses stcp.
// Latency: load 2*WIDTH*CLK_DIV + CLK_DIV clks accept-to-done, clear 2*CLK_DIV clks.
// Backpressure: load_ready low while a transfer/clear runs; clear_req is only honoured when idle, never queued.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    shiftreg_loader_if.slave: data_in/load_valid/load_ready handshake, clear_req, oe_en,
//          busy/done status, and the register pins din, shcp, stcp, oe, sr_reset (all registered).
module shiftreg_loader #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              reset,
  shiftreg_loader_if.slave bus
);

  localparam int              PH_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int              BIT_W    = $clog2(WIDTH);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SH_LO,
    SH_HI,
    LATCH,
    CLR,
    CLR_LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] buf_q, buf_d, buf_shifted;

  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic din_q, din_d;
  logic shcp_q, shcp_d;
  logic stcp_q, stcp_d;
  logic oe_q, oe_d;
  logic sr_reset_q, sr_reset_d;

  logic ph_last;
  logic take_clear;
  logic take_load;
  logic fin_d;

  assign ph_last = (ph_q == PH_LAST);

  // ready_q marks the handshake window: IDLE, and also the final clk of
  // LATCH/CLR_LATCH (the done cycle). Opening the window in the done cycle
  // lets back-to-back words run with no idle gap. Clear wins over a load.
  assign take_clear = ready_q && bus.clear_req;
  assign take_load  = ready_q && !bus.clear_req && bus.load_valid;

  // The bit on din is always the head of the buffer; the buffer moves one
  // place towards the head after every shcp high phase.
  always_comb begin
    if (MSB_FIRST) begin
      buf_shifted = {buf_q[WIDTH-2:0], 1'b0};
    end else begin
      buf_shifted = {1'b0, buf_q[WIDTH-1:1]};
    end
  end

  // Next-state: each non-IDLE state lasts CLK_DIV clks, timed by ph_q.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    buf_d   = buf_q;

    if (take_clear) begin
      state_d = CLR;
      ph_d    = '0;
    end else if (take_load) begin
      state_d = SH_LO;
      ph_d    = '0;
      bit_d   = '0;
      buf_d   = bus.data_in;
    end else begin
      unique case (state_q)
        IDLE: begin
          ph_d = '0;
        end
        SH_LO: begin
          if (ph_last) begin
            state_d = SH_HI;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        SH_HI: begin
          if (ph_last) begin
            ph_d  = '0;
            buf_d = buf_shifted;
            bit_d = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
              state_d = LATCH;
            end else begin
              state_d = SH_LO;
            end
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        LATCH, CLR_LATCH: begin
          if (ph_last) begin
            state_d = IDLE;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        CLR: begin
          if (ph_last) begin
            state_d = CLR_LATCH;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          ph_d    = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with state_q. shcp is only high in SH_HI and stcp only in the latch
  // states, so they can never overlap; din is only reloaded on entry to
  // SH_LO, i.e. while shcp is low.
  always_comb begin
    fin_d      = ((state_d == LATCH) || (state_d == CLR_LATCH)) && (ph_d == PH_LAST);
    ready_d    = (state_d == IDLE) || fin_d;
    busy_d     = !ready_d;
    done_d     = fin_d;
    shcp_d     = (state_d == SH_HI);
    stcp_d     = (state_d == LATCH) || (state_d == CLR_LATCH);
    sr_reset_d = (state_d != CLR);
    oe_d       = !bus.oe_en;
    din_d      = din_q;
    if (state_d == SH_LO) begin
      din_d = MSB_FIRST ? buf_d[WIDTH-1] : buf_d[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      buf_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      din_q      <= 1'b0;
      shcp_q     <= 1'b0;
      stcp_q     <= 1'b0;
      oe_q       <= 1'b1;
      sr_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      buf_q      <= buf_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      din_q      <= din_d;
      shcp_q     <= shcp_d;
      stcp_q     <= stcp_d;
      oe_q       <= oe_d;
      sr_reset_q <= sr_reset_d;
    end
  end

  // A pending clear closes the load window in the same cycle so the master
  // never sees its word accepted alongside a clear.
  assign bus.load_ready = ready_q && !bus.clear_req;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.din        = din_q;
  assign bus.shcp       = shcp_q;
  assign bus.stcp       = stcp_q;
  assign bus.oe         = oe_q;
  assign bus.sr_reset   = sr_reset_q;

endmodule

// File: tb/tb_shiftreg_loader.sv
// Self-checking bench for shiftreg_loader (WIDTH=8, CLK_DIV=2, MSB_FIRST=1).
// A behavioural model of the external shift register (shift stage + storage
// stage) watches the pins; loads are driven from a vector table plus
// hand-written sequences for back-to-back, clear, oe and mid-load reset.
module tb_shiftreg_loader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  shiftreg_loader_if #(.WIDTH(8)) bus ();

  shiftreg_loader #(
    .WIDTH    (8),
    .CLK_DIV  (2),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- pin monitor / external register model ----------------
  // Runs 1ns after each rising edge; the stimulus process samples at +2ns,
  // so every cycle is already accounted for when it is checked.
  logic       shcp_p = 1'b0;
  logic       stcp_p = 1'b0;
  logic       din_p  = 1'b0;
  logic [7:0] sh_m     = 8'h00;
  logic [7:0] st_m     = 8'h00;
  logic [7:0] din_hist = 8'h00;
  int n_shcp = 0, n_stcp = 0, n_srr_lo = 0, n_done = 0, viol = 0;

  always @(posedge clk) begin
    #1;
    if (bus.shcp && !shcp_p) begin
      din_hist = {din_hist[6:0], bus.din};
      sh_m     = {sh_m[6:0], bus.din};
      n_shcp++;
    end
    if (!bus.sr_reset) sh_m = 8'h00;
    if (bus.stcp && !stcp_p) st_m = sh_m;
    if (bus.stcp) n_stcp++;
    if (!bus.sr_reset) n_srr_lo++;
    if (bus.done) n_done++;
    if (bus.shcp && bus.stcp) viol++;
    if (bus.shcp && (bus.din !== din_p)) viol++;
    shcp_p = bus.shcp;
    stcp_p = bus.stcp;
    din_p  = bus.din;
  end

  int s_shcp, s_stcp, s_srr_lo, s_done;

  task automatic snap();
    s_shcp   = n_shcp;
    s_stcp   = n_stcp;
    s_srr_lo = n_srr_lo;
    s_done   = n_done;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offers one word when load_ready is high; lat counts clks from the accept
  // cycle to the cycle done is seen.
  task automatic do_load(input logic [7:0] d, output int lat);
    int w;
    w = 0;
    while (bus.load_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    bus.data_in    = d;
    bus.load_valid = 1'b1;
    snap();
    tick();
    lat = 1;
    bus.load_valid = 1'b0;
    bus.data_in    = ~d;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    while (bus.done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_din;  // din at successive shcp rises, first bit in [7]
    logic [7:0] exp_q;    // register outputs q7..q0 after the latch
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   total;
    int   seen;
    logic [7:0] prev_q;

    vecs[0] = '{8'hA5, 8'b1010_0101, 8'hA5};
    vecs[1] = '{8'h01, 8'b0000_0001, 8'h01};
    vecs[2] = '{8'h80, 8'b1000_0000, 8'h80};
    vecs[3] = '{8'h5A, 8'b0101_1010, 8'h5A};
    vecs[4] = '{8'hC3, 8'b1100_0011, 8'hC3};
    vecs[5] = '{8'h7E, 8'b0111_1110, 8'h7E};

    reset          = 1'b0;
    bus.data_in    = 8'h00;
    bus.load_valid = 1'b0;
    bus.clear_req  = 1'b0;
    bus.oe_en      = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_oe",         {31'd0, bus.oe},         32'd1);
    check("rst_sr_reset",   {31'd0, bus.sr_reset},   32'd0);
    check("rst_shcp",       {31'd0, bus.shcp},       32'd0);
    check("rst_stcp",       {31'd0, bus.stcp},       32'd0);
    check("rst_din",        {31'd0, bus.din},        32'd0);
    check("rst_busy",       {31'd0, bus.busy},       32'd0);
    check("rst_done",       {31'd0, bus.done},       32'd0);
    check("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("rel_ready_before_clk", {31'd0, bus.load_ready}, 32'd0);
    tick();
    check("rel_ready",    {31'd0, bus.load_ready}, 32'd1);
    check("rel_sr_reset", {31'd0, bus.sr_reset},   32'd1);
    check("rel_busy",     {31'd0, bus.busy},       32'd0);

    // ---- output enable follows ~oe_en one clk later ----
    bus.oe_en = 1'b1;
    #1;
    check("oe_en_not_yet", {31'd0, bus.oe}, 32'd1);
    tick();
    check("oe_en_follow", {31'd0, bus.oe}, 32'd0);

    // ---- table-driven loads (each accepted on the previous done cycle) ----
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].data, lat);
      check($sformatf("v%0d_latency", i),    lat,                  32'd34);
      check($sformatf("v%0d_din_seq", i),    {24'd0, din_hist},    {24'd0, vecs[i].exp_din});
      check($sformatf("v%0d_shcp_rises", i), n_shcp - s_shcp,      32'd8);
      check($sformatf("v%0d_stcp_clks", i),  n_stcp - s_stcp,      32'd2);
      check($sformatf("v%0d_q", i),          {24'd0, st_m},        {24'd0, vecs[i].exp_q});
      check($sformatf("v%0d_done_pulses", i), n_done - s_done,     32'd1);
      check($sformatf("v%0d_oe", i),         {31'd0, bus.oe},      32'd0);
    end

    // ---- back-to-back FF then 00 with load_valid held ----
    bus.data_in    = 8'hFF;
    bus.load_valid = 1'b1;
    snap();
    total = 0;
    seen  = 0;
    while (seen < 2 && total < 200) begin
      tick();
      total++;
      if (total == 1) bus.data_in = 8'h00;
      if (bus.done === 1'b1) begin
        seen++;
        if (seen == 1) begin
          check("b2b_first_done", total, 32'd34);
          check("b2b_ready_on_done", {31'd0, bus.load_ready}, 32'd1);
          check("b2b_q_ff", {24'd0, st_m}, 32'hFF);
        end
      end else if (seen == 1 && bus.load_valid) begin
        bus.load_valid = 1'b0;
        check("b2b_second_accepted", {31'd0, bus.busy}, 32'd1);
      end
    end
    check("b2b_total",    total,              32'd68);
    check("b2b_q_00",     {24'd0, st_m},      32'h00);
    check("b2b_dones",    n_done - s_done,    32'd2);
    check("b2b_shcp",     n_shcp - s_shcp,    32'd16);

    // ---- oe_en toggling and clear_req during a load ----
    bus.data_in    = 8'h96;
    bus.load_valid = 1'b1;
    snap();
    tick();
    lat = 1;
    bus.load_valid = 1'b0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (lat == 5) begin
        bus.oe_en = 1'b0;
        #1;
        check("oe_off_not_yet", {31'd0, bus.oe}, 32'd0);
      end
      if (lat == 8)  bus.clear_req = 1'b1;
      if (lat == 9)  bus.clear_req = 1'b0;
      if (lat == 12) bus.oe_en = 1'b1;
      tick();
      lat++;
      if (lat == 6)  check("oe_off_follow", {31'd0, bus.oe}, 32'd1);
      if (lat == 13) check("oe_on_follow",  {31'd0, bus.oe}, 32'd0);
    end
    check("oe_load_latency", lat,                   32'd34);
    check("oe_load_q",       {24'd0, st_m},         32'h96);
    check("oe_load_din_seq", {24'd0, din_hist},     32'h96);
    check("midclr_no_srr",   n_srr_lo - s_srr_lo,   32'd0);
    check("midclr_stcp",     n_stcp - s_stcp,       32'd2);
    tick();
    check("midclr_not_queued", {31'd0, bus.busy}, 32'd0);

    // ---- clear_req and load_valid together in IDLE ----
    bus.clear_req  = 1'b1;
    bus.load_valid = 1'b1;
    bus.data_in    = 8'h77;
    #1;
    check("clr_blocks_ready", {31'd0, bus.load_ready}, 32'd0);
    snap();
    tick();
    total = 1;
    bus.clear_req = 1'b0;
    check("clr_busy", {31'd0, bus.busy}, 32'd1);
    while (bus.done !== 1'b1 && total < 100) begin
      tick();
      total++;
    end
    check("clr_latency",   total,               32'd4);
    check("clr_srr_clks",  n_srr_lo - s_srr_lo, 32'd2);
    check("clr_stcp_clks", n_stcp - s_stcp,     32'd2);
    check("clr_q_zero",    {24'd0, st_m},       32'h00);
    check("clr_ready_on_done", {31'd0, bus.load_ready}, 32'd1);
    snap();
    tick();
    lat = 1;
    bus.load_valid = 1'b0;
    bus.data_in    = 8'h00;
    check("clr_then_load_accepted", {31'd0, bus.busy}, 32'd1);
    while (bus.done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check("clr_then_load_latency", lat,           32'd34);
    check("clr_then_load_q",       {24'd0, st_m}, 32'h77);

    // ---- reset pulled low 10 clks into a load of 3C ----
    bus.data_in    = 8'h3C;
    bus.load_valid = 1'b1;
    prev_q = st_m;
    snap();
    tick();
    lat = 1;
    bus.load_valid = 1'b0;
    while (lat < 10) begin
      tick();
      lat++;
    end
    reset = 1'b0;
    #1;
    check("abort_oe",         {31'd0, bus.oe},         32'd1);
    check("abort_sr_reset",   {31'd0, bus.sr_reset},   32'd0);
    check("abort_shcp",       {31'd0, bus.shcp},       32'd0);
    check("abort_stcp",       {31'd0, bus.stcp},       32'd0);
    check("abort_din",        {31'd0, bus.din},        32'd0);
    check("abort_busy",       {31'd0, bus.busy},       32'd0);
    check("abort_load_ready", {31'd0, bus.load_ready}, 32'd0);
    repeat (4) tick();
    check("abort_no_done",   n_done - s_done,  32'd0);
    check("abort_q_kept",    {24'd0, st_m},    {24'd0, prev_q});
    reset = 1'b1;
    tick();
    check("abort_rel_ready",    {31'd0, bus.load_ready}, 32'd1);
    check("abort_rel_sr_reset", {31'd0, bus.sr_reset},   32'd1);
    check("abort_rel_oe",       {31'd0, bus.oe},         32'd0);
    repeat (3) tick();
    check("abort_rel_idle", {31'd0, bus.busy}, 32'd0);

    check("pin_rule_violations", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
